prbs_req_arbiter: RTL and testbench

// - Shares one 32-bit Galois LFSR PRBS source between NUM_REQ requesters with a round-robin grant.
// - Sequences the source: warm-up after reset or reseed, one LFSR step per delivered word, run-time reseed.
// - Sits between the PRNG datapath and its consumers. Each consumer receives unique, non-overlapping words.

---
 rtl/prbs_pkg.sv | 21 ++
 rtl/prbs_lfsr32.sv | 32 +++
 rtl/prbs_req_arbiter.sv | 151 +++++++++++++++
 tb/tb_prbs_req_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// Purpose: shared constants, state encoding and seed helper for the PRBS request arbiter.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package prbs_pkg;

  localparam int          PRBS_W        = 32;
  localparam logic [31:0] PRBS_TAPS_DEF = 32'h8020_0003;  // x^32+x^22+x^2+x+1
  localparam logic [31:0] PRBS_SEED_DEF = 32'hACE1_2468;

  typedef enum logic {
    WARM = 1'b0,
    RUN  = 1'b1
  } arb_state_t;

  // An all-zero Galois state locks up, so a zero seed falls back to a known-good one.
  function automatic logic [PRBS_W-1:0] safe_seed(input logic [PRBS_W-1:0] val,
                                                  input logic [PRBS_W-1:0] fallback);
    return (val == '0) ? fallback : val;
  endfunction

endpackage

// File: rtl/prbs_lfsr32.sv
// Purpose: 32-bit Galois LFSR register with load and single-step controls.
// Latency: state updates on the edge after step/load; load has priority over step.
// Backpressure: none; the owner decides when to step.
module prbs_lfsr32
  import prbs_pkg::*;
#(
  parameter logic [PRBS_W-1:0] SEED = PRBS_SEED_DEF,
  parameter logic [PRBS_W-1:0] TAPS = PRBS_TAPS_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              step,
  input  logic              load,
  input  logic [PRBS_W-1:0] load_val,
  output logic [PRBS_W-1:0] state
);

  // A zero SEED parameter would also lock up, so guard it the same way as runtime seeds.
  localparam logic [PRBS_W-1:0] SEED_SAFE = (SEED == '0) ? PRBS_SEED_DEF : SEED;

  // Reseed wins over a step; a step shifts right and folds the taps in when bit 0 falls out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= SEED_SAFE;
    end else if (load) begin
      state <= safe_seed(load_val, SEED_SAFE);
    end else if (step) begin
      state <= (state >> 1) ^ (state[0] ? TAPS : '0);
    end
  end

endmodule

// File: rtl/prbs_req_arbiter.sv
// Purpose: round-robin share of one PRBS source among NUM_REQ requesters, with warm-up and reseed.
//          Optional per-requester grant counters when PRBS_ARB_STATS_EN is defined.
// Latency: req -> gnt/rdata one edge; WARMUP+1 cycles of busy after reset or reseed.
// Backpressure: requesters hold req until their gnt bit pulses; one grant per cycle, no idle gaps.
module prbs_req_arbiter
  import prbs_pkg::*;
#(
  parameter int                NUM_REQ = 4,
  parameter logic [PRBS_W-1:0] SEED    = PRBS_SEED_DEF,
  parameter logic [PRBS_W-1:0] TAPS    = PRBS_TAPS_DEF,
  parameter int                WARMUP  = 32,
  localparam int               IDXW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PRBS_W-1:0]  rdata,
  input  logic               seed_load,
  input  logic [PRBS_W-1:0]  seed_val,
`ifdef PRBS_ARB_STATS_EN
  input  logic [IDXW-1:0]    stat_sel,
  output logic [15:0]        stat_cnt,
`endif
  output logic               busy
);

  localparam logic [7:0] WARM_INIT = 8'(WARMUP);

  arb_state_t          fsm_state;
  logic [7:0]          warm_cnt;
  logic [IDXW-1:0]     rr_ptr;
  logic [PRBS_W-1:0]   lfsr;

  logic                found;
  logic [IDXW-1:0]     pick_idx;
  logic [IDXW-1:0]     next_ptr;
  logic [NUM_REQ-1:0]  pick_onehot;
  logic                lfsr_step;
  logic                grant_now;

  // First requesting index at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    int              cand;
    logic [IDXW-1:0] cand_idx;
    found    = 1'b0;
    pick_idx = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IDXW'(cand);
      if (!found && req[cand_idx]) begin
        found    = 1'b1;
        pick_idx = cand_idx;
      end
    end
  end

  // Pointer moves just past the winner; one-hot grant vector for the winner.
  always_comb begin
    next_ptr    = (int'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + IDXW'(1);
    pick_onehot = NUM_REQ'(1) << pick_idx;
  end

  // A grant consumes the current word; warm-up burns words; a reseed suppresses both.
  always_comb begin
    grant_now = (fsm_state == RUN) && found && !seed_load;
    lfsr_step = !seed_load &&
                (((fsm_state == WARM) && (warm_cnt != 8'd0)) || grant_now);
  end

  prbs_lfsr32 #(
    .SEED (SEED),
    .TAPS (TAPS)
  ) u_lfsr (
    .clk      (clk),
    .reset    (reset),
    .step     (lfsr_step),
    .load     (seed_load),
    .load_val (seed_val),
    .state    (lfsr)
  );

  // Sequencer: warm-up countdown, round-robin grants, registered gnt/rdata/busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_state <= WARM;
      warm_cnt  <= WARM_INIT;
      rr_ptr    <= '0;
      gnt       <= '0;
      rdata     <= '0;
      busy      <= 1'b1;
    end else if (seed_load) begin
      // Pending requests stay pending and rr_ptr is kept so fairness carries across the reseed.
      fsm_state <= WARM;
      warm_cnt  <= WARM_INIT;
      gnt       <= '0;
      busy      <= 1'b1;
    end else begin
      case (fsm_state)
        WARM: begin
          gnt <= '0;
          if (warm_cnt != 8'd0) begin
            warm_cnt <= warm_cnt - 8'd1;
          end else begin
            fsm_state <= RUN;
            busy      <= 1'b0;
          end
        end
        RUN: begin
          if (found) begin
            gnt    <= pick_onehot;
            rdata  <= lfsr;
            rr_ptr <= next_ptr;
          end else begin
            gnt <= '0;
          end
        end
        default: begin
          fsm_state <= WARM;
          gnt       <= '0;
          busy      <= 1'b1;
        end
      endcase
    end
  end

`ifdef PRBS_ARB_STATS_EN
  logic [15:0] stat_q [NUM_REQ];

  // Saturating per-requester grant counts; a reseed starts a fresh measurement window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) stat_q[i] <= '0;
    end else if (seed_load) begin
      for (int i = 0; i < NUM_REQ; i++) stat_q[i] <= '0;
    end else if (grant_now && (stat_q[pick_idx] != 16'hFFFF)) begin
      stat_q[pick_idx] <= stat_q[pick_idx] + 16'd1;
    end
  end

  // Out-of-range selects read as zero rather than aliasing another requester.
  always_comb begin
    stat_cnt = '0;
    if (int'(stat_sel) < NUM_REQ) stat_cnt = stat_q[stat_sel];
  end
`endif

endmodule

// File: tb/tb_prbs_req_arbiter.sv
// Purpose: directed self-checking bench for prbs_req_arbiter (SEED=1, NUM_REQ=4).
// Latency: outputs sampled on the falling edge, half a cycle after the updating edge.
// Backpressure: requests held by the bench until the expected grants have been observed.
module tb_prbs_req_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic        seed_load;
  logic [31:0] seed_val;
  logic [3:0]  gnt, gnt_w;
  logic [31:0] rdata, rdata_w;
  logic        busy, busy_w;
`ifdef PRBS_ARB_STATS_EN
  logic [1:0]  stat_sel;
  logic [15:0] stat_cnt, stat_cnt_w;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  prbs_req_arbiter #(.NUM_REQ(4), .SEED(32'h1), .WARMUP(0)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .gnt       (gnt),
    .rdata     (rdata),
    .seed_load (seed_load),
    .seed_val  (seed_val),
`ifdef PRBS_ARB_STATS_EN
    .stat_sel  (stat_sel),
    .stat_cnt  (stat_cnt),
`endif
    .busy      (busy)
  );

  prbs_req_arbiter #(.NUM_REQ(4), .SEED(32'h1), .WARMUP(2)) dut_w2 (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .gnt       (gnt_w),
    .rdata     (rdata_w),
    .seed_load (seed_load),
    .seed_val  (seed_val),
`ifdef PRBS_ARB_STATS_EN
    .stat_sel  (stat_sel),
    .stat_cnt  (stat_cnt_w),
`endif
    .busy      (busy_w)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req       = '0;
    seed_load = 1'b0;
    seed_val  = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    n_vec++;
    if (gnt !== 4'b0000) begin n_err++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
    n_vec++;
    if (rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h expected 00000000", rdata); end
    n_vec++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL reset_busy: got %b expected 1", busy); end
  endtask

  task automatic test_single();
    logic [31:0] exp_d [3] = '{32'h0000_0001, 32'h8020_0003, 32'hC030_0002};
    do_reset();
    req = 4'b0001;
    tick();
    n_vec++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      n_err++; $display("FAIL single_first_edge: got gnt=%b busy=%b expected gnt=0000 busy=0", gnt, busy);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (gnt !== 4'b0001 || rdata !== exp_d[i]) begin
        n_err++; $display("FAIL single_grant%0d: got gnt=%b rdata=%h expected gnt=0001 rdata=%h", i, gnt, rdata, exp_d[i]);
      end
    end
    req = 4'b0000;
    tick();
    n_vec++;
    if (gnt !== 4'b0000 || rdata !== 32'hC030_0002) begin
      n_err++; $display("FAIL idle_hold: got gnt=%b rdata=%h expected gnt=0000 rdata=c0300002", gnt, rdata);
    end
    req = 4'b0001;
    tick();
    n_vec++;
    if (gnt !== 4'b0001 || rdata !== 32'h6018_0001) begin
      n_err++; $display("FAIL idle_no_step: got gnt=%b rdata=%h expected gnt=0001 rdata=60180001", gnt, rdata);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0]  exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [31:0] exp_d [5] = '{32'h0000_0001, 32'h8020_0003, 32'hC030_0002, 32'h6018_0001, 32'hB02C_0003};
    do_reset();
    req = 4'b1111;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      n_vec++;
      if (gnt !== exp_g[i] || rdata !== exp_d[i]) begin
        n_err++; $display("FAIL rr_grant%0d: got gnt=%b rdata=%h expected gnt=%b rdata=%h", i, gnt, rdata, exp_g[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_warmup();
    do_reset();
    req = 4'b0100;
    tick();
    n_vec++;
    if (busy_w !== 1'b1) begin n_err++; $display("FAIL warm_busy1: got %b expected 1", busy_w); end
    tick();
    n_vec++;
    if (busy_w !== 1'b1 || gnt_w !== 4'b0000) begin
      n_err++; $display("FAIL warm_busy2: got busy=%b gnt=%b expected busy=1 gnt=0000", busy_w, gnt_w);
    end
    tick();
    n_vec++;
    if (busy_w !== 1'b0 || gnt_w !== 4'b0000) begin
      n_err++; $display("FAIL warm_exit: got busy=%b gnt=%b expected busy=0 gnt=0000", busy_w, gnt_w);
    end
    tick();
    n_vec++;
    if (gnt_w !== 4'b0100 || rdata_w !== 32'hC030_0002) begin
      n_err++; $display("FAIL warm_first_word: got gnt=%b rdata=%h expected gnt=0100 rdata=c0300002", gnt_w, rdata_w);
    end
  endtask

  task automatic test_reseed();
    do_reset();
    req = 4'b0001;
    tick();
    tick();
    req       = 4'b0010;
    seed_load = 1'b1;
    seed_val  = 32'h0;
    tick();
    seed_load = 1'b0;
    n_vec++;
    if (gnt !== 4'b0000 || busy !== 1'b1) begin
      n_err++; $display("FAIL reseed_zero_block: got gnt=%b busy=%b expected gnt=0000 busy=1", gnt, busy);
    end
    tick();
    n_vec++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      n_err++; $display("FAIL reseed_zero_warm: got gnt=%b busy=%b expected gnt=0000 busy=0", gnt, busy);
    end
    tick();
    n_vec++;
    if (gnt !== 4'b0010 || rdata !== 32'h0000_0001) begin
      n_err++; $display("FAIL reseed_zero_word: got gnt=%b rdata=%h expected gnt=0010 rdata=00000001", gnt, rdata);
    end
    seed_load = 1'b1;
    seed_val  = 32'h0000_0003;
    tick();
    seed_load = 1'b0;
    n_vec++;
    if (gnt !== 4'b0000 || busy !== 1'b1) begin
      n_err++; $display("FAIL reseed_val_block: got gnt=%b busy=%b expected gnt=0000 busy=1", gnt, busy);
    end
    tick();
    tick();
    n_vec++;
    if (gnt !== 4'b0010 || rdata !== 32'h0000_0003) begin
      n_err++; $display("FAIL reseed_val_word: got gnt=%b rdata=%h expected gnt=0010 rdata=00000003", gnt, rdata);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 4'b1111;
    tick();
    tick();
    tick();
    n_vec++;
    if (gnt !== 4'b0010) begin n_err++; $display("FAIL burst_before_reset: got %b expected 0010", gnt); end
    #2;
    reset = 1'b1;
    #1;
    n_vec++;
    if (gnt !== 4'b0000 || busy !== 1'b1 || rdata !== 32'h0) begin
      n_err++; $display("FAIL async_reset: got gnt=%b busy=%b rdata=%h expected gnt=0000 busy=1 rdata=00000000", gnt, busy, rdata);
    end
    @(negedge clk);
    reset = 1'b0;
    req   = 4'b0000;
  endtask

`ifdef PRBS_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    stat_sel = 2'd2;
    req      = 4'b0100;
    tick();
    repeat (5) tick();
    req = 4'b0000;
    #1;
    n_vec++;
    if (stat_cnt !== 16'd5) begin n_err++; $display("FAIL stats_count: got %0d expected 5", stat_cnt); end
    stat_sel = 2'd0;
    #1;
    n_vec++;
    if (stat_cnt !== 16'd0) begin n_err++; $display("FAIL stats_other: got %0d expected 0", stat_cnt); end
    stat_sel = 2'd2;
    @(negedge clk);
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    n_vec++;
    if (stat_cnt !== 16'd0) begin n_err++; $display("FAIL stats_clear: got %0d expected 0", stat_cnt); end
  endtask
`endif

  initial begin
    reset     = 1'b1;
    req       = '0;
    seed_load = 1'b0;
    seed_val  = '0;
`ifdef PRBS_ARB_STATS_EN
    stat_sel  = '0;
`endif
    test_reset();
    test_single();
    test_round_robin();
    test_warmup();
    test_reseed();
    test_async_reset();
`ifdef PRBS_ARB_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
